// File: rtl/regfile_dump_if.sv
// Beat stream from the register-file dump reader: one (address, data) pair per
// valid/ready handshake, with out_last marking the final register index.
interface regfile_dump_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_addr;
    logic [XLEN-1:0] out_data;
    logic            out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Sequential debug reader: walks the register file through a spare async read
// port and streams each (index, value) as a handshaked beat.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int SKIP_X0  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            done,
    regfile_dump_if.master  out_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [4:0] FIRST    = (SKIP_X0 != 0) ? 5'd1 : 5'd0;
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t          state_q;
    logic [4:0]      ptr_q;
    logic            valid_q;
    logic [4:0]      addr_q;
    logic [XLEN-1:0] data_q;
    logic            last_q;
    logic            done_q;

    logic [4:0]      ptr_d;
    logic            handshake;
    logic            at_last;

    assign ptr_d     = ptr_q + 5'd1;
    assign handshake = valid_q && out_if.out_ready;
    assign at_last   = (ptr_q == LAST_IDX);

    // The read port follows ptr directly, so the capture edge samples rd_data for ptr.
    assign rd_addr          = ptr_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_addr  = addr_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_last  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 5'd0;
            valid_q <= 1'b0;
            addr_q  <= 5'd0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_q   <= FIRST;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        ptr_q   <= 5'd0;
                        state_q <= IDLE;
                    end else begin
                        data_q  <= rd_data;
                        addr_q  <= ptr_q;
                        last_q  <= at_last;
                        valid_q <= 1'b1;
                        ptr_q   <= ptr_d;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    // abort outranks a same-cycle handshake; that beat is dropped.
                    if (abort) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        ptr_q   <= 5'd0;
                        state_q <= IDLE;
                    end else if (handshake) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ptr_q   <= 5'd0;
                            state_q <= IDLE;
                        end else begin
                            data_q <= rd_data;
                            addr_q <= ptr_q;
                            last_q <= at_last;
                            ptr_q  <= ptr_d;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    ptr_q   <= 5'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: table-driven full dump plus hand-written
// SKIP_X0, back-pressure, abort, async reset and write-during-dump sequences.
module tb_regfile_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b0;
    logic        start0 = 1'b0;
    logic        abort0 = 1'b0;
    logic        start1 = 1'b0;
    logic        abort1 = 1'b0;
    logic        busy0, busy1, done0, done1;
    logic [4:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic [31:0] regs [32];
    logic [31:0] got  [32];

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];

    regfile_dump_if #(.XLEN(32)) if0 ();
    regfile_dump_if #(.XLEN(32)) if1 ();

    regfile_dump #(.NUM_REGS(32), .XLEN(32), .SKIP_X0(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .busy(busy0),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .done(done0), .out_if(if0)
    );

    regfile_dump #(.NUM_REGS(32), .XLEN(32), .SKIP_X0(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .done(done1), .out_if(if1)
    );

    typedef struct {
        logic        start;
        logic        busy;
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        logic        done;
        logic [4:0]  rd;
    } vec_t;

    vec_t tbl [36];
    int   checks   = 0;
    int   failures = 0;
    int   beats, found, dn, exp_a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Runs one dump on dut0. mode 0: out_ready always high; mode 1: 1-on/2-off.
    // wr_n: iteration at which x7 is overwritten; st_n: iteration with a stray start.
    task automatic do_dump0(input int mode, input string tag, input int wr_n, input int st_n);
        int          nb, nd, first_n, last_n, ea;
        logic        stall, rdy;
        logic [4:0]  pa;
        logic [31:0] pd;
        nb = 0; nd = 0; first_n = -1; last_n = -1; ea = 0;
        stall = 1'b0; pa = 5'd0; pd = 32'd0;
        @(negedge clk);
        start0 = 1'b1;
        if0.out_ready = (mode == 0);
        for (int n = 1; n < 400 && nd == 0; n++) begin
            @(negedge clk);
            start0 = (n == st_n);
            if (n == wr_n) regs[7] = 32'hDEAD_BEEF;
            rdy = (mode == 0) ? 1'b1 : ((n % 3) == 0);
            if0.out_ready = rdy;
            if (stall) begin
                chk({tag, "_stall_valid"}, 32'(if0.out_valid), 32'd1);
                chk({tag, "_stall_addr"}, 32'(if0.out_addr), 32'(pa));
                chk({tag, "_stall_data"}, if0.out_data, pd);
            end
            if (if0.out_valid) begin
                if (first_n < 0) begin
                    first_n = n;
                    if (mode == 0) chk({tag, "_first_latency"}, 32'(n), 32'd2);
                end
                if (rdy) begin
                    chk($sformatf("%s_addr_b%0d", tag, nb), 32'(if0.out_addr), 32'(ea));
                    chk($sformatf("%s_data_b%0d", tag, nb), if0.out_data, regs[ea[4:0]]);
                    chk($sformatf("%s_last_b%0d", tag, nb), 32'(if0.out_last), 32'(ea == 31));
                    got[ea[4:0]] = if0.out_data;
                    ea++;
                    nb++;
                    last_n = n;
                end
            end
            stall = if0.out_valid && !rdy;
            pa    = if0.out_addr;
            pd    = if0.out_data;
            if (done0) begin
                nd++;
                chk({tag, "_done_timing"}, 32'(n), 32'(last_n + 1));
                chk({tag, "_busy_at_done"}, 32'(busy0), 32'd0);
            end
        end
        chk({tag, "_beats"}, 32'(nb), 32'd32);
        chk({tag, "_done_seen"}, 32'(nd), 32'd1);
        @(negedge clk);
        if0.out_ready = 1'b1;
        chk({tag, "_done_single"}, 32'(done0), 32'd0);
        chk({tag, "_idle_after"}, 32'(busy0), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
            got[i]  = 32'd0;
        end
        for (int v = 0; v < 36; v++) begin
            tbl[v].start = (v == 0);
            tbl[v].busy  = (v >= 1 && v <= 33);
            tbl[v].valid = (v >= 2 && v <= 33);
            tbl[v].addr  = 5'(v - 2);
            tbl[v].data  = (v == 2) ? 32'd0 : 32'h1000_0000 + 32'(v - 2);
            tbl[v].last  = (v == 33);
            tbl[v].done  = (v == 34);
            tbl[v].rd    = (v >= 2 && v <= 33) ? 5'(v - 1) : 5'd0;
        end
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_valid0", 32'(if0.out_valid), 32'd0);
        chk("rst_addr0", 32'(if0.out_addr), 32'd0);
        chk("rst_data0", if0.out_data, 32'd0);
        chk("rst_last0", 32'(if0.out_last), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_rd_addr0", 32'(rd_addr0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;

        // Full-throughput dump, cycle by cycle
        for (int v = 0; v < 36; v++) begin
            @(negedge clk);
            start0 = tbl[v].start;
            if0.out_ready = 1'b1;
            chk($sformatf("tbl%0d_busy", v), 32'(busy0), 32'(tbl[v].busy));
            chk($sformatf("tbl%0d_valid", v), 32'(if0.out_valid), 32'(tbl[v].valid));
            chk($sformatf("tbl%0d_last", v), 32'(if0.out_last), 32'(tbl[v].last));
            chk($sformatf("tbl%0d_done", v), 32'(done0), 32'(tbl[v].done));
            chk($sformatf("tbl%0d_rd_addr", v), 32'(rd_addr0), 32'(tbl[v].rd));
            if (tbl[v].valid) begin
                chk($sformatf("tbl%0d_addr", v), 32'(if0.out_addr), 32'(tbl[v].addr));
                chk($sformatf("tbl%0d_data", v), if0.out_data, tbl[v].data);
            end
        end

        // SKIP_X0=1: 31 beats starting at x1
        @(negedge clk);
        start1 = 1'b1;
        if1.out_ready = 1'b1;
        beats = 0; exp_a = 1; dn = 0;
        for (int n = 1; n < 80 && dn == 0; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (if1.out_valid) begin
                chk($sformatf("skip_addr_b%0d", beats), 32'(if1.out_addr), 32'(exp_a));
                chk($sformatf("skip_data_b%0d", beats), if1.out_data, regs[exp_a[4:0]]);
                chk($sformatf("skip_last_b%0d", beats), 32'(if1.out_last), 32'(exp_a == 31));
                exp_a++;
                beats++;
            end
            if (done1) begin
                dn = 1;
                chk("skip_busy_at_done", 32'(busy1), 32'd0);
            end
        end
        chk("skip_beats", 32'(beats), 32'd31);
        chk("skip_done_seen", 32'(dn), 32'd1);

        // Back-pressure 1-on/2-off
        do_dump0(1, "stall", -1, -1);

        // Abort in the cycle beat 5 is accepted
        @(negedge clk);
        start0 = 1'b1;
        if0.out_ready = 1'b1;
        found = 0;
        for (int n = 0; n < 60 && found == 0; n++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (if0.out_valid && if0.out_addr == 5'd5) found = 1;
        end
        chk("abort_reach_addr5", 32'(found), 32'd1);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_valid", 32'(if0.out_valid), 32'd0);
        chk("abort_last", 32'(if0.out_last), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_rd_addr", 32'(rd_addr0), 32'd0);
        @(negedge clk);
        chk("abort_done_later", 32'(done0), 32'd0);
        do_dump0(0, "restart", -1, -1);

        // Asynchronous reset while sending addr 12
        @(negedge clk);
        start0 = 1'b1;
        found = 0;
        for (int n = 0; n < 60 && found == 0; n++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (if0.out_valid && if0.out_addr == 5'd12) found = 1;
        end
        chk("rst_reach_addr12", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_valid", 32'(if0.out_valid), 32'd0);
        chk("arst_addr", 32'(if0.out_addr), 32'd0);
        chk("arst_data", if0.out_data, 32'd0);
        chk("arst_last", 32'(if0.out_last), 32'd0);
        chk("arst_done", 32'(done0), 32'd0);
        chk("arst_rd_addr", 32'(rd_addr0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_dump0(0, "post_rst", -1, -1);

        // x7 rewritten just before its capture edge; stray start while busy
        do_dump0(0, "x7", 8, 15);
        chk("x7_beat7", got[7], 32'hDEAD_BEEF);
        chk("x7_beat6", got[6], 32'h1000_0006);
        chk("x7_beat8", got[8], 32'h1000_0008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
